dram_responder: RTL

- Responder end of the memory-stage ↔ data-memory interface. The memory stage issues read/write requests; this block returns the read word (rd) and owns the on-chip data RAM.
- Services each request with a configurable number of wait states.
- Drives a stall request to the hazard unit while a request is outstanding.
- Sits between the memory stage and the data-side SRAM array, which this block instantiates.

---
 rtl/dram_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - data-memory responder with wait states, stall request and owned SRAM array
// Optional misalignment trap: define DRAM_MISALIGN_CHECK_EN.
module dram_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mread_en,
  input  logic [31:0] mread_addr,
  input  logic [1:0]  mread_size,
  input  logic        mwrite_en,
  input  logic [31:0] mwrite_addr,
  input  logic [1:0]  mwrite_size,
  input  logic [31:0] mwrite_data,
  input  logic        flush,
  output logic [31:0] rd,
  output logic        data_ok,
  output logic        stall,
  output logic        addr_err
);
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_rd_q, is_rd_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     rd_q, rd_d;
  logic            data_ok_q, data_ok_d;
  logic            addr_err_q, addr_err_d;
  logic [31:0]     mem_q [2**ADDR_WIDTH];

  logic            req;
  logic [AW-1:0]   in_addr;
  logic [1:0]      in_size;
  logic            in_misalign;
  logic [AW-1:0]   cur_addr;
  logic [1:0]      cur_size;
  logic [31:0]     cur_wdata;
  logic            cur_rd, cur_wr;
  logic            access;
  logic            mem_we;
  logic [31:0]     mem_old;
  logic [31:0]     mem_wdata;
  logic            unused_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00: begin
        for (int i = 0; i < 4; i++)
          if (off == 2'(i)) m[8*i +: 8] = wd[7:0];
      end
      2'b01: begin
        if (off[1]) m[31:16] = wd[15:0];
        else        m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  // A combined read+write is one request at the write address.
  assign req     = mread_en | mwrite_en;
  assign in_addr = mwrite_en ? mwrite_addr[AW-1:0] : mread_addr[AW-1:0];
  assign in_size = mwrite_en ? mwrite_size : mread_size;

`ifdef DRAM_MISALIGN_CHECK_EN
  assign in_misalign = ((in_size == 2'b01) && in_addr[0]) ||
                       (in_size[1] && (in_addr[1:0] != 2'b00));
`else
  assign in_misalign = 1'b0;
`endif

  assign unused_bits = ^{mread_addr[31:AW], mwrite_addr[31:AW]};

  // With WAIT_CYCLES=0 the access happens straight out of IDLE, so use live inputs there.
  always_comb begin
    cur_addr  = addr_q;
    cur_size  = size_q;
    cur_wdata = wdata_q;
    cur_rd    = is_rd_q;
    cur_wr    = is_wr_q;
    if (state_q == S_IDLE) begin
      cur_addr  = in_addr;
      cur_size  = in_size;
      cur_wdata = mwrite_data;
      cur_rd    = mread_en;
      cur_wr    = mwrite_en;
    end
  end

  assign mem_old   = mem_q[cur_addr[AW-1:2]];
  assign mem_wdata = merge_lanes(mem_old, cur_wdata, cur_addr[1:0], cur_size);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    is_rd_d    = is_rd_q;
    is_wr_d    = is_wr_q;
    rd_d       = rd_q;
    data_ok_d  = 1'b0;
    addr_err_d = 1'b0;
    access     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !flush) begin
          if (in_misalign) begin
            addr_err_d = 1'b1;
          end else begin
            addr_d  = in_addr;
            size_d  = in_size;
            wdata_d = mwrite_data;
            is_rd_d = mread_en;
            is_wr_d = mwrite_en;
            if (WAIT_CYCLES == 0) begin
              state_d = S_RESP;
              access  = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (access) begin
      data_ok_d = 1'b1;
      if (cur_rd) rd_d = mem_old;
    end
  end

  assign mem_we = access && cur_wr && resetn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      wdata_q    <= 32'd0;
      is_rd_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      rd_q       <= 32'd0;
      data_ok_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      is_rd_q    <= is_rd_d;
      is_wr_q    <= is_wr_d;
      rd_q       <= rd_d;
      data_ok_q  <= data_ok_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array contents survive reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_addr[AW-1:2]] <= mem_wdata;
  end

  assign rd       = rd_q;
  assign data_ok  = data_ok_q;
  assign addr_err = addr_err_q;
  assign stall    = ((state_q == S_IDLE) && req && !in_misalign) || (state_q == S_WAIT);

endmodule
